approx_mult_seq: RTL and testbench
==================================

APPROX_MULT_SEQ -- requirements
Module: approx_mult_seq

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width in bits; legal values are multiples of 4 from 8 to 32.
REQ-002 SHALL derive localparam D = W/4, the number of 4-bit digits per operand.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port a, input, W, the multiplicand.
REQ-006 SHALL have port b, input, W, the multiplier.
REQ-007 SHALL have port approx, input, 1, the mode select: 0 = exact, 1 = approximate.
REQ-008 SHALL have port in_valid, input, 1, meaning a, b and approx are valid.
REQ-009 SHALL have port in_ready, output, 1, meaning the block can accept an operand pair.
REQ-010 SHALL have port r, output, 2W, the product.
REQ-011 SHALL have port out_valid, output, 1, meaning r is valid.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer takes r.

Function
REQ-013 SHALL implement three states:
- IDLE: in_ready=1.
- CALC: one 4x4 digit-block product per cycle.
- DONE: out_valid=1.
REQ-014 SHALL, in IDLE with in_valid=1, register a, b and approx, clear the 2W-bit accumulator, and go to CALC.
REQ-015 SHALL hold in_ready=0 outside IDLE; in_valid outside IDLE is ignored.
REQ-016 SHALL visit digit blocks (i,j), with i = a digit and j = b digit, in j-outer, i-inner ascending order.
REQ-017 SHALL, for each visited block, add (a_i*b_j) << 4(i+j) to the accumulator.
REQ-018 SHALL, when approx=1, skip every block with i+j < D-1: skipped blocks contribute 0 and consume no cycle.
REQ-019 SHALL use exact visited-block counts: exact mode visits D*D blocks; approximate mode visits D*D - D(D-1)/2 blocks.
REQ-020 SHALL have the following latency: with the operand accepted at edge T, out_valid=1 from cycle T+1+blocks; for W=8 this is T+5 in exact mode and T+4 in approximate mode.
REQ-021 SHALL, after the last block, load r from the accumulator and enter DONE.
REQ-022 SHALL hold r and out_valid stable in DONE until out_ready=1.
REQ-023 SHALL go from DONE to IDLE on out_ready=1, with in_ready=1 in the following cycle; no same-cycle accept.
REQ-024 SHALL size the accumulator at 2W bits, so no overflow is possible; approximate results are never greater than exact results.
REQ-025 SHALL treat a=0 or b=0 like any other operand: no early exit, same latency.
REQ-026 SHALL keep out_ready=1 outside DONE without effect.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force state to IDLE and clear r, the accumulator, the operand registers and the block counters to 0.
REQ-028 SHALL give the following output values during and after reset: in_ready=1 (IDLE), out_valid=0, r=0.
REQ-029 SHALL, on rst asserted mid-CALC or in DONE, abort the operation and emit no result.
REQ-030 SHALL give rst priority over in_valid and out_ready in the same cycle.

Structure
REQ-031 SHALL place in package approx_mult_pkg:
- the state enum (IDLE, CALC, DONE);
- the digit width constant 4;
- a function returning the visited-block count for (D, approx).
REQ-032 SHALL instantiate exactly one combinational sub-module mul4x4 (4-bit x 4-bit -> 8-bit exact product), shared across all blocks.
REQ-033 SHALL reject illegal W at elaboration.

Verification
REQ-034 SHALL cover, at W=8: a=255, b=255, approx=0 -> r=65025, out_valid at T+5.
REQ-035 SHALL cover, at W=8: a=255, b=255, approx=1 -> r=64800, out_valid at T+4.
REQ-036 SHALL cover, at W=8: a=0x12, b=0x34 -> r=936 in exact mode; r=928 in approximate mode.
REQ-037 SHALL cover, at W=16: a=0xFFFF, b=0xFFFF, approx=0 -> r=0xFFFE0001 after 16 CALC cycles; approx=1 -> 10 CALC cycles and r no greater than the exact result.
REQ-038 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> r and out_valid stable, in_ready=0; new in_valid pulses ignored.
REQ-039 SHALL cover reset mid-CALC: rst pulsed at the second CALC cycle -> next cycle in_ready=1, out_valid=0, r=0; the following operand 3*5 yields r=15.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the sequential digit-block multiplier.
package approx_mult_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Number of 4x4 blocks actually visited for a D-digit operand pair.
    function automatic int unsigned block_count(input int unsigned d, input logic approx);
        return approx ? (d * d - (d * (d - 1)) / 2) : (d * d);
    endfunction

endpackage

// File: rtl/mul4x4.sv
// Exact 4-bit x 4-bit unsigned product, purely combinational.
module mul4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);

    assign p = 8'(x) * 8'(y);

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential multiplier accumulating one 4x4 digit-block product per cycle;
// approximate mode drops the low-order blocks with i+j < D-1.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | one digit block accumulated per cycle
// DONE  | result held on r with out_valid=1 until out_ready
module approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             approx,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2*W-1:0]   r,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int D  = W / DIGIT_W;
    localparam int CW = $clog2(D);
    localparam int BW = $clog2(D * D);

    if (W < 8 || W > 32 || (W % 4) != 0) begin : g_bad_w
        $error("approx_mult_seq: W must be a multiple of 4 between 8 and 32");
    end

    state_t           state, state_nxt;
    logic [W-1:0]     a_reg, b_reg;
    logic             approx_reg;
    logic [2*W-1:0]   acc;
    logic [CW-1:0]    i_cnt, j_cnt;
    logic [BW-1:0]    blk_left;
    logic [3:0]       digit_a, digit_b;
    logic [7:0]       prod;
    logic [2*W-1:0]   term;

    assign digit_a = 4'(a_reg >> (DIGIT_W * int'(i_cnt)));
    assign digit_b = 4'(b_reg >> (DIGIT_W * int'(j_cnt)));

    mul4x4 u_mul (
        .x (digit_a),
        .y (digit_b),
        .p (prod)
    );

    assign term = {{(2*W-8){1'b0}}, prod} << (DIGIT_W * (int'(i_cnt) + int'(j_cnt)));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (blk_left == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            approx_reg <= 1'b0;
            acc        <= '0;
            r          <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            blk_left   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        approx_reg <= approx;
                        acc        <= '0;
                        j_cnt      <= '0;
                        // Approximate row 0 only keeps its top digit.
                        i_cnt      <= approx ? CW'(D - 1) : '0;
                        blk_left   <= BW'(block_count(D, approx) - 1);
                    end
                end
                CALC: begin
                    blk_left <= blk_left - 1'b1;
                    if (blk_left == '0) begin
                        r <= acc + term;
                    end else begin
                        acc <= acc + term;
                        if (i_cnt == CW'(D - 1)) begin
                            j_cnt <= j_cnt + 1'b1;
                            // First kept digit of row j+1 is D-1-(j+1).
                            i_cnt <= approx_reg ? (CW'(D - 2) - j_cnt) : '0;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Directed scoreboard bench for approx_mult_seq at W=8 and W=16.
module tb_approx_mult_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  a8, b8;
    logic        ap8, iv8, rdy8, ov8, ordy8;
    logic [15:0] r8;
    logic [15:0] a16, b16;
    logic        ap16, iv16, rdy16, ov16, ordy16;
    logic [31:0] r16;

    approx_mult_seq #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .approx(ap8), .in_valid(iv8),
        .in_ready(rdy8), .r(r8), .out_valid(ov8), .out_ready(ordy8)
    );

    approx_mult_seq #(.W(16)) u_dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .approx(ap16), .in_valid(iv16),
        .in_ready(rdy16), .r(r16), .out_valid(ov16), .out_ready(ordy16)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] q8[$];
    logic [31:0] q16[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input int d, input logic ap);
        logic [31:0] sum = '0;
        for (int j = 0; j < d; j++)
            for (int i = 0; i < d; i++)
                if (!(ap && (i + j < d - 1)))
                    sum += 32'(((av >> (4 * i)) & 16'hF) * ((bv >> (4 * j)) & 16'hF)) << (4 * (i + j));
        return sum;
    endfunction

    // Latency = rising edges from the accept edge to the first edge seeing out_valid.
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic ap, input int lat_exp, input logic [15:0] r_exp, input int hold);
        int n;
        logic [15:0] e;
        @(negedge clk);
        a8 = av; b8 = bv; ap8 = ap; iv8 = 1'b1;
        @(posedge clk);
        q8.push_back(r_exp);
        @(negedge clk);
        iv8 = 1'b0;
        n = 1;
        while (!ov8 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat_exp));
        for (int k = 0; k < hold; k++) begin
            iv8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
            check({tag, "_hold_valid"}, 64'(ov8), 64'd1);
            check({tag, "_hold_r"}, 64'(r8), 64'(q8[0]));
            check({tag, "_hold_in_ready"}, 64'(rdy8), 64'd0);
            @(negedge clk);
        end
        iv8 = 1'b0;
        e = (q8.size() > 0) ? q8.pop_front() : 16'hXXXX;
        check({tag, "_r"}, 64'(r8), 64'(e));
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
        check({tag, "_in_ready_after"}, 64'(rdy8), 64'd1);
        check({tag, "_out_valid_after"}, 64'(ov8), 64'd0);
    endtask

    task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ap, input int calc_exp, input logic [31:0] r_exp);
        int n, calc;
        logic [31:0] e;
        @(negedge clk);
        a16 = av; b16 = bv; ap16 = ap; iv16 = 1'b1;
        @(posedge clk);
        q16.push_back(r_exp);
        @(negedge clk);
        iv16 = 1'b0;
        n = 1;
        calc = 0;
        while (!ov16 && n < 60) begin
            if (!rdy16) calc++;
            @(negedge clk);
            n++;
        end
        check({tag, "_calc_cycles"}, 64'(calc), 64'(calc_exp));
        check({tag, "_latency"}, 64'(n), 64'(calc_exp + 1));
        e = (q16.size() > 0) ? q16.pop_front() : 32'hXXXXXXXX;
        check({tag, "_r"}, 64'(r16), 64'(e));
        check({tag, "_le_exact"}, 64'(r16 <= 32'hFFFE0001), 64'd1);
        ordy16 = 1'b1;
        @(negedge clk);
        ordy16 = 1'b0;
        check({tag, "_in_ready_after"}, 64'(rdy16), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        a8 = '0; b8 = '0; ap8 = 1'b0; iv8 = 1'b0; ordy8 = 1'b0;
        a16 = '0; b16 = '0; ap16 = 1'b0; iv16 = 1'b0; ordy16 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(rdy8), 64'd1);
        check("rst_out_valid", 64'(ov8), 64'd0);
        check("rst_r", 64'(r8), 64'd0);
        check("rst16_r", 64'(r16), 64'd0);
        rst = 1'b0;

        run8("ff_exact", 8'hFF, 8'hFF, 1'b0, 5, 16'd65025, 0);
        run8("ff_approx", 8'hFF, 8'hFF, 1'b1, 4, 16'd64800, 0);
        run8("h12_exact", 8'h12, 8'h34, 1'b0, 5, 16'd936, 0);
        run8("h12_approx", 8'h12, 8'h34, 1'b1, 4, 16'd928, 0);
        run8("zero_a", 8'h00, 8'hC7, 1'b0, 5, 16'd0, 0);
        run8("zero_b_apx", 8'h9D, 8'h00, 1'b1, 4, 16'd0, 0);
        run8("mixed_apx", 8'hA5, 8'h3C, 1'b1, 4, model(16'hA5, 16'h3C, 2, 1'b1), 0);

        ordy8 = 1'b1;
        @(negedge clk);
        check("idle_out_ready_no_effect", 64'(rdy8), 64'd1);
        ordy8 = 1'b0;

        run8("backpressure", 8'h12, 8'h34, 1'b0, 5, 16'd936, 5);
        @(negedge clk);
        check("bp_no_ghost_result", 64'(ov8), 64'd0);

        // Abort: accept, then assert rst during the second CALC cycle.
        @(negedge clk);
        a8 = 8'hAB; b8 = 8'hCD; ap8 = 1'b0; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 64'(rdy8), 64'd1);
        check("abort_out_valid", 64'(ov8), 64'd0);
        check("abort_r", 64'(r8), 64'd0);
        run8("after_abort", 8'd3, 8'd5, 1'b0, 5, 16'd15, 0);

        run16("w16_exact", 16'hFFFF, 16'hFFFF, 1'b0, 16, 32'hFFFE0001);
        run16("w16_approx", 16'hFFFF, 16'hFFFF, 1'b1, 10, model(16'hFFFF, 16'hFFFF, 4, 1'b1));
        run16("w16_mixed", 16'h1234, 16'hBEEF, 1'b1, 10, model(16'h1234, 16'hBEEF, 4, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
